// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Bundles every signal of the ID/EX issue stage apart from clock and reset.
//   master : the surrounding pipeline, which drives the decoded ID fields,
//            the stall/flush controls and the EX/MEM and MEM/WB forwarding
//            taps, and receives the ALU operands and EX-stage control.
//   slave  : alu_issue_stage itself.
// Ports carried:
//   id_*            decoded instruction from ID (operands, register numbers,
//                   alu_src, alu_op, funct, mem_read, reg_write, valid)
//   stall, flush    pipeline freeze / bubble insertion
//   exmem_*, memwb_* forwarding sources (write enable, rd, value)
//   data1, data2,
//   ALUControl      ALU operands and operation select
//   ex_*            EX-stage control passed on to EX/MEM, plus store data
//   hazard_stall    load-use hazard, upstream must hold PC and IF/ID
// ---------------------------------------------------------------------------
interface alu_issue_if #(
   parameter int WIDTH = 32,
   parameter int RA_W  = 5
);
   logic                    id_valid;
   logic signed [WIDTH-1:0] id_rs_data;
   logic signed [WIDTH-1:0] id_rt_data;
   logic signed [WIDTH-1:0] id_imm;
   logic [RA_W-1:0]         id_rs;
   logic [RA_W-1:0]         id_rt;
   logic [RA_W-1:0]         id_rd;
   logic                    id_alu_src;
   logic [1:0]              id_alu_op;
   logic [5:0]              id_funct;
   logic                    id_mem_read;
   logic                    id_reg_write;
   logic                    stall;
   logic                    flush;
   logic                    exmem_reg_write;
   logic [RA_W-1:0]         exmem_rd;
   logic signed [WIDTH-1:0] exmem_result;
   logic                    memwb_reg_write;
   logic [RA_W-1:0]         memwb_rd;
   logic signed [WIDTH-1:0] memwb_result;

   logic signed [WIDTH-1:0] data1;
   logic signed [WIDTH-1:0] data2;
   logic [3:0]              ALUControl;
   logic                    ex_valid;
   logic [RA_W-1:0]         ex_rd;
   logic                    ex_mem_read;
   logic                    ex_reg_write;
   logic signed [WIDTH-1:0] ex_store_data;
   logic                    hazard_stall;

   modport master (
      output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
             id_alu_src, id_alu_op, id_funct, id_mem_read, id_reg_write,
             stall, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      input  data1, data2, ALUControl, ex_valid, ex_rd, ex_mem_read,
             ex_reg_write, ex_store_data, hazard_stall
   );

   modport slave (
      input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
             id_alu_src, id_alu_op, id_funct, id_mem_read, id_reg_write,
             stall, flush,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      output data1, data2, ALUControl, ex_valid, ex_rd, ex_mem_read,
             ex_reg_write, ex_store_data, hazard_stall
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// ID/EX pipeline register in front of the 32-bit ALU. Captures the decoded
// instruction, forwards operands from EX/MEM and MEM/WB, decodes
// alu_op/funct into ALUControl and detects load-use hazards.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears every register
//   ifc    alu_issue_if.slave; ID inputs, stall/flush, forwarding taps,
//          ALU operands/control, EX-stage control, hazard_stall
// ---------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int WIDTH = 32,
   parameter int RA_W  = 5
) (
   input  logic        clk,
   input  logic        reset,
   alu_issue_if.slave  ifc
);
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_BAD = 4'b1111;

   logic                    vld_p0;
   logic                    mem_read_p0;
   logic                    reg_write_p0;
   logic                    alu_src_p0;
   logic [RA_W-1:0]         rs_p0;
   logic [RA_W-1:0]         rt_p0;
   logic [RA_W-1:0]         rd_p0;
   logic [1:0]              alu_op_p0;
   logic [5:0]              funct_p0;
   logic signed [WIDTH-1:0] rs_data_p0;
   logic signed [WIDTH-1:0] rt_data_p0;
   logic signed [WIDTH-1:0] imm_p0;

   logic                    hazard;
   logic signed [WIDTH-1:0] fwd_rs;
   logic signed [WIDTH-1:0] fwd_rt;

   // The younger producer (EX/MEM) has the newer value, so it wins.
   function automatic logic signed [WIDTH-1:0] forward_operand(
      input logic [RA_W-1:0]         src,
      input logic signed [WIDTH-1:0] reg_val,
      input logic                    em_we,
      input logic [RA_W-1:0]         em_rd,
      input logic signed [WIDTH-1:0] em_val,
      input logic                    mw_we,
      input logic [RA_W-1:0]         mw_rd,
      input logic signed [WIDTH-1:0] mw_val
   );
      logic signed [WIDTH-1:0] res;
      res = reg_val;
      if (em_we && (em_rd != '0) && (em_rd == src))
         res = em_val;
      else if (mw_we && (mw_rd != '0) && (mw_rd == src))
         res = mw_val;
      return res;
   endfunction

   // Only ADD and SUB exist downstream; everything else is flagged 1111.
   function automatic logic [3:0] alu_decode(
      input logic [1:0] op,
      input logic [5:0] funct
   );
      logic [3:0] ctl;
      ctl = ALU_BAD;
      case (op)
         2'b00: ctl = ALU_ADD;
         2'b01: ctl = ALU_SUB;
         2'b10: begin
            case (funct)
               6'b100000, 6'b100001: ctl = ALU_ADD;
               6'b100010, 6'b100011: ctl = ALU_SUB;
               default:              ctl = ALU_BAD;
            endcase
         end
         default: ctl = ALU_BAD;
      endcase
      return ctl;
   endfunction

   // Load in EX whose destination is read by the instruction now in ID.
   assign hazard = vld_p0 & mem_read_p0 & (rd_p0 != '0) & ifc.id_valid &
                   ((rd_p0 == ifc.id_rs) | (rd_p0 == ifc.id_rt));

   // ---- ID -> EX boundary ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p0       <= 1'b0;
         mem_read_p0  <= 1'b0;
         reg_write_p0 <= 1'b0;
         alu_src_p0   <= 1'b0;
         rs_p0        <= '0;
         rt_p0        <= '0;
         rd_p0        <= '0;
         alu_op_p0    <= 2'b00;
         funct_p0     <= 6'b0;
         rs_data_p0   <= '0;
         rt_data_p0   <= '0;
         imm_p0       <= '0;
      end else if (ifc.flush || (!ifc.stall && hazard)) begin
         // Bubble: only the control bits matter, data fields are left as-is.
         vld_p0       <= 1'b0;
         mem_read_p0  <= 1'b0;
         reg_write_p0 <= 1'b0;
      end else if (!ifc.stall) begin
         vld_p0       <= ifc.id_valid;
         mem_read_p0  <= ifc.id_mem_read & ifc.id_valid;
         reg_write_p0 <= ifc.id_reg_write & ifc.id_valid;
         alu_src_p0   <= ifc.id_alu_src;
         rs_p0        <= ifc.id_rs;
         rt_p0        <= ifc.id_rt;
         rd_p0        <= ifc.id_rd;
         alu_op_p0    <= ifc.id_alu_op;
         funct_p0     <= ifc.id_funct;
         rs_data_p0   <= ifc.id_rs_data;
         rt_data_p0   <= ifc.id_rt_data;
         imm_p0       <= ifc.id_imm;
      end
   end

   // ---- EX operand selection (combinational) ----
   assign fwd_rs = forward_operand(rs_p0, rs_data_p0,
                                   ifc.exmem_reg_write, ifc.exmem_rd, ifc.exmem_result,
                                   ifc.memwb_reg_write, ifc.memwb_rd, ifc.memwb_result);
   assign fwd_rt = forward_operand(rt_p0, rt_data_p0,
                                   ifc.exmem_reg_write, ifc.exmem_rd, ifc.exmem_result,
                                   ifc.memwb_reg_write, ifc.memwb_rd, ifc.memwb_result);

   assign ifc.data1         = fwd_rs;
   assign ifc.data2         = alu_src_p0 ? imm_p0 : fwd_rt;
   assign ifc.ex_store_data = fwd_rt;
   assign ifc.ALUControl    = alu_decode(alu_op_p0, funct_p0);
   assign ifc.ex_valid      = vld_p0;
   assign ifc.ex_rd         = rd_p0;
   assign ifc.ex_mem_read   = mem_read_p0;
   assign ifc.ex_reg_write  = reg_write_p0;
   assign ifc.hazard_stall  = hazard;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed scenarios followed by a randomized run, all compared against a
// behavioural model of the EX-stage contents.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   alu_issue_if #(.WIDTH(32), .RA_W(5)) ifc ();

   alu_issue_stage #(.WIDTH(32), .RA_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .ifc   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of what the EX stage holds; known=0 after a bubble, when the data
   // fields are unspecified.
   typedef struct {
      bit        known;
      bit        valid, mem_read, reg_write, alu_src;
      bit [4:0]  rs, rt, rd;
      bit [1:0]  op;
      bit [5:0]  funct;
      bit [31:0] rs_data, rt_data, imm;
   } ex_t;
   ex_t m;

   function automatic bit [31:0] mdl_fwd(bit [4:0] r, bit [31:0] v);
      if (ifc.exmem_reg_write && ifc.exmem_rd != 0 && ifc.exmem_rd == r) return ifc.exmem_result;
      if (ifc.memwb_reg_write && ifc.memwb_rd != 0 && ifc.memwb_rd == r) return ifc.memwb_result;
      return v;
   endfunction

   function automatic bit [3:0] mdl_ctl(bit [1:0] op, bit [5:0] funct);
      if (op == 2'd0) return 4'b0010;
      if (op == 2'd1) return 4'b0110;
      if (op == 2'd2 && (funct == 6'h20 || funct == 6'h21)) return 4'b0010;
      if (op == 2'd2 && (funct == 6'h22 || funct == 6'h23)) return 4'b0110;
      return 4'b1111;
   endfunction

   function automatic bit mdl_hazard();
      return m.valid && m.mem_read && m.rd != 0 && ifc.id_valid === 1'b1 &&
             (m.rd == ifc.id_rs || m.rd == ifc.id_rt);
   endfunction

   task automatic mdl_reset();
      m = '{default: 0};
      m.known = 1'b1;
   endtask

   task automatic tick();
      ex_t n;
      n = m;
      if (ifc.flush || (!ifc.stall && mdl_hazard())) begin
         n.valid = 0; n.mem_read = 0; n.reg_write = 0; n.known = 0;
      end else if (!ifc.stall) begin
         n.known     = 1;
         n.valid     = ifc.id_valid;
         n.mem_read  = ifc.id_mem_read & ifc.id_valid;
         n.reg_write = ifc.id_reg_write & ifc.id_valid;
         n.alu_src   = ifc.id_alu_src;
         n.rs = ifc.id_rs; n.rt = ifc.id_rt; n.rd = ifc.id_rd;
         n.op = ifc.id_alu_op; n.funct = ifc.id_funct;
         n.rs_data = ifc.id_rs_data; n.rt_data = ifc.id_rt_data; n.imm = ifc.id_imm;
      end
      @(posedge clk);
      #1;
      m = n;
   endtask

   task automatic fwd_idle();
      ifc.exmem_reg_write = 0; ifc.exmem_rd = 0; ifc.exmem_result = 0;
      ifc.memwb_reg_write = 0; ifc.memwb_rd = 0; ifc.memwb_result = 0;
   endtask

   task automatic drive_idle();
      ifc.id_valid = 0; ifc.id_rs_data = 0; ifc.id_rt_data = 0; ifc.id_imm = 0;
      ifc.id_rs = 0; ifc.id_rt = 0; ifc.id_rd = 0; ifc.id_alu_src = 0;
      ifc.id_alu_op = 0; ifc.id_funct = 0; ifc.id_mem_read = 0; ifc.id_reg_write = 0;
      ifc.stall = 0; ifc.flush = 0;
   endtask

   task automatic drive_instr(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd,
                              bit [31:0] rsd, bit [31:0] rtd, bit [31:0] imm,
                              bit src, bit [1:0] op, bit [5:0] funct, bit mr, bit rw);
      ifc.id_valid = v; ifc.id_rs = rs; ifc.id_rt = rt; ifc.id_rd = rd;
      ifc.id_rs_data = rsd; ifc.id_rt_data = rtd; ifc.id_imm = imm;
      ifc.id_alu_src = src; ifc.id_alu_op = op; ifc.id_funct = funct;
      ifc.id_mem_read = mr; ifc.id_reg_write = rw;
   endtask

   task automatic test_reset();
      checks++; if (ifc.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %b want 0", ifc.ex_valid); end
      checks++; if (ifc.ALUControl !== 4'b0010) begin errors++; $display("FAIL rst_aluctl: got %b want 0010", ifc.ALUControl); end
      checks++; if (ifc.data1 !== 32'h0 || ifc.data2 !== 32'h0) begin errors++; $display("FAIL rst_data: got %h/%h want 0/0", ifc.data1, ifc.data2); end
      checks++; if (ifc.hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_hazard: got %b want 0", ifc.hazard_stall); end
      // Mid-run asynchronous reset.
      drive_instr(1, 5'd1, 5'd2, 5'd3, 32'hAAAA_0001, 32'hBBBB_0002, 32'h3, 0, 2'd1, 6'h0, 0, 1);
      tick();
      checks++; if (ifc.ex_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b want 1", ifc.ex_valid); end
      #3;
      reset = 1'b1;
      #1;
      mdl_reset();
      checks++; if (ifc.ex_valid !== 1'b0 || ifc.ex_reg_write !== 1'b0 || ifc.ex_mem_read !== 1'b0)
         begin errors++; $display("FAIL arst_ctrl: got v=%b rw=%b mr=%b want 0 0 0", ifc.ex_valid, ifc.ex_reg_write, ifc.ex_mem_read); end
      checks++; if (ifc.data1 !== 32'h0 || ifc.data2 !== 32'h0 || ifc.ex_store_data !== 32'h0)
         begin errors++; $display("FAIL arst_data: got %h/%h/%h want 0", ifc.data1, ifc.data2, ifc.ex_store_data); end
      checks++; if (ifc.ALUControl !== 4'b0010 || ifc.ex_rd !== 5'd0)
         begin errors++; $display("FAIL arst_ctl_rd: got %b/%0d want 0010/0", ifc.ALUControl, ifc.ex_rd); end
      #1;
      reset = 1'b0;
      drive_idle();
      tick();
   endtask

   task automatic test_forward();
      drive_instr(1, 5'd5, 5'd6, 5'd7, 32'h33, 32'h44, 32'h55, 0, 2'd0, 6'h0, 0, 1);
      tick();
      drive_idle();
      ifc.exmem_reg_write = 1; ifc.exmem_rd = 5; ifc.exmem_result = 32'h11;
      ifc.memwb_reg_write = 1; ifc.memwb_rd = 5; ifc.memwb_result = 32'h22;
      #1;
      checks++; if (ifc.data1 !== 32'h11) begin errors++; $display("FAIL fwd_exmem_prio: got %h want 11", ifc.data1); end
      ifc.exmem_reg_write = 0;
      #1;
      checks++; if (ifc.data1 !== 32'h22) begin errors++; $display("FAIL fwd_memwb: got %h want 22", ifc.data1); end
      ifc.exmem_reg_write = 1; ifc.exmem_rd = 0; ifc.memwb_rd = 0;
      #1;
      checks++; if (ifc.data1 !== 32'h33) begin errors++; $display("FAIL fwd_none: got %h want 33", ifc.data1); end
      ifc.memwb_rd = 6; ifc.memwb_result = 32'h66;
      #1;
      checks++; if (ifc.data2 !== 32'h66 || ifc.ex_store_data !== 32'h66)
         begin errors++; $display("FAIL fwd_rt: got %h/%h want 66/66", ifc.data2, ifc.ex_store_data); end
      fwd_idle();
      drive_instr(1, 5'd0, 5'd0, 5'd4, 32'h77, 32'h88, 32'h0, 0, 2'd0, 6'h0, 0, 1);
      tick();
      ifc.exmem_reg_write = 1; ifc.exmem_rd = 0; ifc.exmem_result = 32'h11;
      ifc.memwb_reg_write = 1; ifc.memwb_rd = 0; ifc.memwb_result = 32'h22;
      #1;
      checks++; if (ifc.data1 !== 32'h77 || ifc.ex_store_data !== 32'h88)
         begin errors++; $display("FAIL fwd_r0: got %h/%h want 77/88", ifc.data1, ifc.ex_store_data); end
      fwd_idle();
      drive_idle();
   endtask

   task automatic test_decode();
      bit [1:0] ops [8]   = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
      bit [5:0] fns [8]   = '{6'h22, 6'h24, 6'h20, 6'h21, 6'h23, 6'h3F, 6'h00, 6'h20};
      bit [3:0] want [8]  = '{4'b0110, 4'b1111, 4'b0010, 4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b1111};
      for (int i = 0; i < 8; i++) begin
         drive_instr(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 0, ops[i], fns[i], 0, 1);
         tick();
         #1;
         checks++; if (ifc.ALUControl !== want[i])
            begin errors++; $display("FAIL decode[%0d]: got %b want %b", i, ifc.ALUControl, want[i]); end
      end
      drive_instr(1, 5'd1, 5'd2, 5'd3, 32'h1, 32'h1234, 32'hFFFF_FFFC, 1, 2'd0, 6'h0, 0, 1);
      tick();
      checks++; if (ifc.data2 !== 32'hFFFF_FFFC || ifc.ALUControl !== 4'b0010)
         begin errors++; $display("FAIL imm_sel: got %h/%b want fffffffc/0010", ifc.data2, ifc.ALUControl); end
      checks++; if (ifc.ex_store_data !== 32'h1234)
         begin errors++; $display("FAIL store_data: got %h want 1234", ifc.ex_store_data); end
      // Invalid instruction: control forced low, fields still captured.
      drive_instr(0, 5'd1, 5'd2, 5'd13, 32'h1, 32'h2, 32'h0, 0, 2'd0, 6'h0, 1, 1);
      tick();
      checks++; if (ifc.ex_valid !== 1'b0 || ifc.ex_mem_read !== 1'b0 || ifc.ex_reg_write !== 1'b0 || ifc.ex_rd !== 5'd13)
         begin errors++; $display("FAIL invalid_capture: got v=%b mr=%b rw=%b rd=%0d want 0 0 0 13",
                                  ifc.ex_valid, ifc.ex_mem_read, ifc.ex_reg_write, ifc.ex_rd); end
      drive_idle();
   endtask

   task automatic test_load_use();
      drive_instr(1, 5'd1, 5'd2, 5'd8, 32'h100, 32'h0, 32'h4, 1, 2'd0, 6'h0, 1, 1);
      tick();
      drive_instr(1, 5'd8, 5'd3, 5'd9, 32'h5, 32'h6, 32'h0, 0, 2'd2, 6'h20, 0, 1);
      #1;
      checks++; if (ifc.hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_hazard: got %b want 1", ifc.hazard_stall); end
      tick();
      checks++; if (ifc.ex_valid !== 1'b0 || ifc.hazard_stall !== 1'b0 || ifc.ex_mem_read !== 1'b0)
         begin errors++; $display("FAIL lu_bubble: got v=%b hz=%b mr=%b want 0 0 0", ifc.ex_valid, ifc.hazard_stall, ifc.ex_mem_read); end
      ifc.exmem_reg_write = 1; ifc.exmem_rd = 8; ifc.exmem_result = 32'hABCD;
      tick();
      checks++; if (ifc.ex_valid !== 1'b1 || ifc.data1 !== 32'hABCD || ifc.ex_rd !== 5'd9)
         begin errors++; $display("FAIL lu_resume: got v=%b d1=%h rd=%0d want 1 abcd 9", ifc.ex_valid, ifc.data1, ifc.ex_rd); end
      fwd_idle();
      // A load targeting r0 never causes a hazard.
      drive_instr(1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 1, 2'd0, 6'h0, 1, 1);
      tick();
      drive_instr(1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 0, 2'd0, 6'h0, 0, 1);
      #1;
      checks++; if (ifc.hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_r0: got %b want 0", ifc.hazard_stall); end
      drive_idle();
      tick();
   endtask

   task automatic test_stall();
      drive_instr(1, 5'd10, 5'd11, 5'd12, 32'h1010, 32'h2020, 32'h3030, 0, 2'd1, 6'h0, 1, 1);
      tick();
      ifc.stall = 1;
      for (int i = 0; i < 3; i++) begin
         drive_instr($urandom_range(0, 1), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                     1'($urandom), 2'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
         tick();
         checks++; if (ifc.data1 !== 32'h1010 || ifc.data2 !== 32'h2020 || ifc.ALUControl !== 4'b0110 || ifc.ex_store_data !== 32'h2020)
            begin errors++; $display("FAIL stall_data[%0d]: got %h %h %b %h want 1010 2020 0110 2020",
                                     i, ifc.data1, ifc.data2, ifc.ALUControl, ifc.ex_store_data); end
         checks++; if (ifc.ex_valid !== 1'b1 || ifc.ex_rd !== 5'd12 || ifc.ex_mem_read !== 1'b1 || ifc.ex_reg_write !== 1'b1)
            begin errors++; $display("FAIL stall_ctrl[%0d]: got v=%b rd=%0d mr=%b rw=%b want 1 12 1 1",
                                     i, ifc.ex_valid, ifc.ex_rd, ifc.ex_mem_read, ifc.ex_reg_write); end
      end
      ifc.flush = 1;
      tick();
      checks++; if (ifc.ex_valid !== 1'b0 || ifc.ex_mem_read !== 1'b0 || ifc.ex_reg_write !== 1'b0)
         begin errors++; $display("FAIL stall_flush: got v=%b mr=%b rw=%b want 0 0 0", ifc.ex_valid, ifc.ex_mem_read, ifc.ex_reg_write); end
      drive_idle();
      tick();
   endtask

   task automatic test_random();
      bit [5:0] fsel [5] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h00};
      for (int i = 0; i < 400; i++) begin
         fsel[4] = 6'($urandom);
         drive_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom),
                     fsel[$urandom_range(0, 4)], $urandom_range(0, 2) == 0, 1'($urandom));
         ifc.stall = ($urandom_range(0, 4) == 0);
         ifc.flush = ($urandom_range(0, 7) == 0);
         ifc.exmem_reg_write = 1'($urandom); ifc.exmem_rd = 5'($urandom_range(0, 7)); ifc.exmem_result = $urandom;
         ifc.memwb_reg_write = 1'($urandom); ifc.memwb_rd = 5'($urandom_range(0, 7)); ifc.memwb_result = $urandom;
         #1;
         checks++; if (ifc.ex_valid !== m.valid || ifc.ex_mem_read !== m.mem_read || ifc.ex_reg_write !== m.reg_write)
            begin errors++; $display("FAIL rnd_ctrl[%0d]: got %b%b%b want %b%b%b", i, ifc.ex_valid, ifc.ex_mem_read,
                                     ifc.ex_reg_write, m.valid, m.mem_read, m.reg_write); end
         checks++; if (ifc.hazard_stall !== mdl_hazard())
            begin errors++; $display("FAIL rnd_hazard[%0d]: got %b want %b", i, ifc.hazard_stall, mdl_hazard()); end
         if (m.known) begin
            checks++; if (ifc.data1 !== mdl_fwd(m.rs, m.rs_data))
               begin errors++; $display("FAIL rnd_data1[%0d]: got %h want %h", i, ifc.data1, mdl_fwd(m.rs, m.rs_data)); end
            checks++; if (ifc.data2 !== (m.alu_src ? m.imm : mdl_fwd(m.rt, m.rt_data)))
               begin errors++; $display("FAIL rnd_data2[%0d]: got %h want %h", i, ifc.data2,
                                        m.alu_src ? m.imm : mdl_fwd(m.rt, m.rt_data)); end
            checks++; if (ifc.ex_store_data !== mdl_fwd(m.rt, m.rt_data))
               begin errors++; $display("FAIL rnd_store[%0d]: got %h want %h", i, ifc.ex_store_data, mdl_fwd(m.rt, m.rt_data)); end
            checks++; if (ifc.ALUControl !== mdl_ctl(m.op, m.funct) || ifc.ex_rd !== m.rd)
               begin errors++; $display("FAIL rnd_ctl_rd[%0d]: got %b/%0d want %b/%0d", i, ifc.ALUControl, ifc.ex_rd,
                                        mdl_ctl(m.op, m.funct), m.rd); end
         end
         tick();
      end
      drive_idle();
      fwd_idle();
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      fwd_idle();
      mdl_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_forward();
      test_decode();
      test_load_use();
      test_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
